// File: rtl/game_ctrl.sv
// Game controller: button debounce, frame tick extraction, collision tracking,
// game FSM and BCD score / hiscore keeping, all in the single clk domain.
module game_ctrl #(
  parameter logic [19:0] DEB_CYCLES = 20'd500000,
  parameter int          SCORE_DIV  = 6,
  parameter int          HOLDOFF    = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        refreshclk,
  input  logic        btn_jump,
  input  logic        btn_down,
  input  logic        isemptyDino,
  input  logic        isemptyObs,
  output logic [1:0]  gamestate,
  output logic        jump,
  output logic        lying,
  output logic [15:0] score,
  output logic [15:0] hiscore,
  output logic        frame_tick
);

  localparam int FW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(SCORE_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLDOFF);

  typedef enum logic [1:0] {
    UNBEGIN = 2'b00,
    RUNNING = 2'b01,
    DEAD    = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [1:0]    jump_sync, down_sync, ref_sync;
  logic          ref_prev;
  logic [19:0]   jump_cnt, jump_cnt_nxt, down_cnt, down_cnt_nxt;
  logic          jump_db, jump_db_nxt, jump_db_prev;
  logic          down_db, down_db_nxt;
  logic          jump_press, ref_edge, overlap, hit;
  logic [FW-1:0] frame_cnt;
  logic [HW-1:0] holdoff;
  logic          start_game, end_game, score_step, holdoff_step;

  // Increment packed BCD, rippling the carry through digits that roll 9 -> 0.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      jump_sync    <= '0;
      down_sync    <= '0;
      ref_sync     <= '0;
      ref_prev     <= 1'b0;
      jump_cnt     <= '0;
      down_cnt     <= '0;
      jump_db      <= 1'b0;
      down_db      <= 1'b0;
      jump_db_prev <= 1'b0;
      frame_tick   <= 1'b0;
    end else begin
      jump_sync    <= {jump_sync[0], btn_jump};
      down_sync    <= {down_sync[0], btn_down};
      ref_sync     <= {ref_sync[0], refreshclk};
      ref_prev     <= ref_sync[1];
      jump_cnt     <= jump_cnt_nxt;
      down_cnt     <= down_cnt_nxt;
      jump_db      <= jump_db_nxt;
      down_db      <= down_db_nxt;
      jump_db_prev <= jump_db;
      frame_tick   <= ref_edge;
    end
  end

  // A level only flips after DEB_CYCLES straight cycles of disagreement.
  always_comb begin
    jump_db_nxt  = jump_db;
    jump_cnt_nxt = '0;
    if (jump_sync[1] != jump_db) begin
      if (jump_cnt == DEB_CYCLES - 20'd1) jump_db_nxt = jump_sync[1];
      else jump_cnt_nxt = jump_cnt + 20'd1;
    end
    down_db_nxt  = down_db;
    down_cnt_nxt = '0;
    if (down_sync[1] != down_db) begin
      if (down_cnt == DEB_CYCLES - 20'd1) down_db_nxt = down_sync[1];
      else down_cnt_nxt = down_cnt + 20'd1;
    end
  end

  assign jump_press = jump_db & ~jump_db_prev;
  assign ref_edge   = ref_sync[1] & ~ref_prev;
  assign overlap    = ~isemptyDino & ~isemptyObs;
  assign jump       = jump_db;
  assign gamestate  = state;

  always_ff @(posedge clk) begin
    if (!rst) state <= UNBEGIN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      UNBEGIN: if (jump_press) state_nxt = RUNNING;
      RUNNING: if (frame_tick && hit) state_nxt = DEAD;
      DEAD:    if (jump_press && holdoff == HOLD_MAX) state_nxt = UNBEGIN;
      default: state_nxt = UNBEGIN;
    endcase
  end

  // Death is checked before scoring, so a fatal tick never adds a point.
  always_comb begin
    start_game   = 1'b0;
    end_game     = 1'b0;
    score_step   = 1'b0;
    holdoff_step = 1'b0;
    unique case (state)
      UNBEGIN: start_game = jump_press;
      RUNNING: begin
        end_game   = frame_tick & hit;
        score_step = frame_tick & ~hit;
      end
      DEAD:    holdoff_step = frame_tick & (holdoff != HOLD_MAX);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      score     <= '0;
      hiscore   <= '0;
      frame_cnt <= '0;
      holdoff   <= '0;
      hit       <= 1'b0;
      lying     <= 1'b0;
    end else begin
      lying <= down_db_nxt & (state_nxt == RUNNING);

      if (start_game)      hit <= 1'b0;
      else if (frame_tick) hit <= overlap;
      else                 hit <= hit | overlap;

      if (start_game) begin
        score     <= '0;
        frame_cnt <= '0;
      end else if (score_step) begin
        if (frame_cnt == FRAME_MAX) begin
          frame_cnt <= '0;
          if (score != 16'h9999) score <= bcd_inc(score);
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end

      // Packed BCD orders the same as its value, so a plain compare suffices.
      if (end_game) begin
        holdoff <= '0;
        if (score > hiscore) hiscore <= score;
      end else if (holdoff_step) begin
        holdoff <= holdoff + HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with short debounce, score divider and holdoff
// so whole games, including score saturation, fit in a short run.
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        refreshclk;
  logic        btn_jump;
  logic        btn_down;
  logic        isemptyDino;
  logic        isemptyObs;
  logic [1:0]  gamestate;
  logic        jump;
  logic        lying;
  logic [15:0] score;
  logic [15:0] hiscore;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;
  logic sawJump;

  game_ctrl #(
    .DEB_CYCLES(20'd4),
    .SCORE_DIV (2),
    .HOLDOFF   (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .refreshclk (refreshclk),
    .btn_jump   (btn_jump),
    .btn_down   (btn_down),
    .isemptyDino(isemptyDino),
    .isemptyObs (isemptyObs),
    .gamestate  (gamestate),
    .jump       (jump),
    .lying      (lying),
    .score      (score),
    .hiscore    (hiscore),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic j, input logic d,
                               input logic dino, input logic obs);
    btn_jump    = j;
    btn_down    = d;
    isemptyDino = dino;
    isemptyObs  = obs;
  endtask

  // Each refreshclk period is two clk; the trailing wait drains the sync pipeline.
  task automatic frameTicks(input int n);
    for (int i = 0; i < n; i++) begin
      refreshclk = 1'b1;
      step(1);
      refreshclk = 1'b0;
      step(1);
    end
    step(4);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_state"}, 16'(gamestate), 16'h0);
    checkOutput({tag, "_jump"}, 16'(jump), 16'h0);
    checkOutput({tag, "_lying"}, 16'(lying), 16'h0);
    checkOutput({tag, "_score"}, score, 16'h0000);
    checkOutput({tag, "_hiscore"}, hiscore, 16'h0000);
    checkOutput({tag, "_tick"}, 16'(frame_tick), 16'h0);
  endtask

  initial begin
    rst        = 1'b0;
    refreshclk = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    step(3);
    checkResetState("reset");
    rst = 1'b1;
    step(1);

    // Frame tick is a single clk, three clk after refreshclk rises.
    refreshclk = 1'b1;
    step(2);
    checkOutput("tick_early", 16'(frame_tick), 16'h0);
    step(1);
    checkOutput("tick_pulse", 16'(frame_tick), 16'h1);
    step(1);
    checkOutput("tick_single", 16'(frame_tick), 16'h0);
    refreshclk = 1'b0;
    step(4);

    // Bouncing jump button never reaches the debounced level.
    sawJump = 1'b0;
    for (int i = 0; i < 20; i++) begin
      btn_jump = ~btn_jump;
      step(2);
      sawJump = sawJump | jump;
    end
    btn_jump = 1'b0;
    step(8);
    checkOutput("bounce_jump", 16'(sawJump), 16'h0);
    checkOutput("bounce_state", 16'(gamestate), 16'h0);

    // Clean press: 2 sync + 4 debounce clk, then the FSM one clk later.
    btn_jump = 1'b1;
    step(5);
    checkOutput("deb_not_yet", 16'(jump), 16'h0);
    step(1);
    checkOutput("deb_jump", 16'(jump), 16'h1);
    checkOutput("deb_state_pre", 16'(gamestate), 16'h0);
    step(1);
    checkOutput("start_state", 16'(gamestate), 16'h1);
    checkOutput("start_score", score, 16'h0000);
    btn_jump = 1'b0;
    step(8);

    // Dino alone on screen is not a collision.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    step(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    frameTicks(1);
    checkOutput("nohit_state", 16'(gamestate), 16'h1);
    frameTicks(6);
    checkOutput("score_3", score, 16'h0003);
    frameTicks(11);
    checkOutput("score_9", score, 16'h0009);
    frameTicks(2);
    checkOutput("score_10", score, 16'h0010);
    frameTicks(1);
    checkOutput("score_10_odd", score, 16'h0010);

    // Collision mid-frame; the next tick would also have scored.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    step(1);
    checkOutput("hit_wait_state", 16'(gamestate), 16'h1);
    refreshclk = 1'b1;
    step(3);
    checkOutput("hit_tick", 16'(frame_tick), 16'h1);
    checkOutput("hit_tick_state", 16'(gamestate), 16'h1);
    step(1);
    checkOutput("dead_state", 16'(gamestate), 16'h2);
    checkOutput("dead_score", score, 16'h0010);
    checkOutput("dead_hiscore", hiscore, 16'h0010);
    refreshclk = 1'b0;
    step(4);

    btn_down = 1'b1;
    step(8);
    checkOutput("dead_lying", 16'(lying), 16'h0);

    // Restart holdoff: early press ignored, press after three ticks accepted.
    frameTicks(1);
    btn_jump = 1'b1;
    step(8);
    checkOutput("holdoff_early", 16'(gamestate), 16'h2);
    btn_jump = 1'b0;
    step(8);
    frameTicks(2);
    btn_jump = 1'b1;
    step(8);
    checkOutput("holdoff_done", 16'(gamestate), 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    step(8);
    btn_jump = 1'b1;
    step(8);
    checkOutput("game2_state", 16'(gamestate), 16'h1);
    checkOutput("game2_score", score, 16'h0000);
    checkOutput("game2_hiscore", hiscore, 16'h0010);
    btn_jump = 1'b0;
    step(8);

    frameTicks(84);
    checkOutput("score_42", score, 16'h0042);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    step(8);
    checkOutput("run_jump", 16'(jump), 16'h1);
    checkOutput("run_lying", 16'(lying), 16'h1);
    checkOutput("run_state", 16'(gamestate), 16'h1);

    // Mid-game reset, buttons still held throughout.
    rst = 1'b0;
    step(1);
    checkResetState("midreset");
    rst = 1'b1;
    step(5);
    checkOutput("post_reset_jump", 16'(jump), 16'h0);
    checkOutput("post_reset_state", 16'(gamestate), 16'h0);
    step(2);
    checkOutput("game3_state", 16'(gamestate), 16'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    step(8);

    frameTicks(19998);
    checkOutput("score_9999", score, 16'h9999);
    frameTicks(4);
    checkOutput("score_sat", score, 16'h9999);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    frameTicks(1);
    checkOutput("dead3_state", 16'(gamestate), 16'h2);
    checkOutput("dead3_hiscore", hiscore, 16'h9999);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 20'd500000: clk cycles a button must be stable before its debounced level changes.
REQ-002 Parameter SCORE_DIV, default 6: frame ticks per score increment while Running.
REQ-003 Parameter HOLDOFF, default 30: frame ticks in Dead before a restart press is accepted.
REQ-004 clk  in  1  system pixel clock; sole clock; every flop on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset; sampled on rising clk.
REQ-006 refreshclk  in  1  frame-rate square wave, treated as data and sampled by clk.
REQ-007 btn_jump  in  1  raw, asynchronous jump button.
REQ-008 btn_down  in  1  raw, asynchronous duck button.
REQ-009 isemptyDino  in  1  0 when the current pixel belongs to the dino sprite.
REQ-010 isemptyObs  in  1  0 when the current pixel belongs to any obstacle.
REQ-011 gamestate  out  2  00 UnBegin, 01 Running, 10 Dead; 11 never driven.
REQ-012 jump  out  1  debounced jump level, held for the whole press.
REQ-013 lying  out  1  debounced duck level; forced 0 outside Running.
REQ-014 score  out  16  4-digit packed BCD current score.
REQ-015 hiscore  out  16  4-digit packed BCD best score since reset.
REQ-016 frame_tick  out  1  one-clk pulse per refreshclk rising edge.

Function
REQ-017 Each button passes through a 2-flop synchroniser, then a counter that updates the debounced level only after DEB_CYCLES consecutive cycles of a differing synchronised value; any bounce restarts the count at 0.
REQ-018 A press event is a 0->1 edge of a debounced level; it lasts exactly one clk.
REQ-019 refreshclk passes through a 2-flop synchroniser; frame_tick asserts on the cycle after a synchronised 0->1 edge is detected.
REQ-020 hit flag sets on any clk where isemptyDino==0 and isemptyObs==0; it clears on frame_tick, and a same-cycle overlap on a frame_tick cycle is carried into the new frame (set wins).
REQ-021 FSM UnBegin -> Running on a jump press event; on entry, score is cleared, and the frame counter and hit flag are cleared.
REQ-022 FSM Running -> Dead on frame_tick when hit (the value before clearing) is 1; score freezes on the same cycle.
REQ-023 On entry to Dead, hiscore <= score when score > hiscore, with the comparison done as an unsigned compare of the packed BCD.
REQ-024 In Dead, a holdoff counter increments on each frame_tick and saturates at HOLDOFF; a jump press event with holdoff == HOLDOFF moves the FSM to UnBegin, and any earlier press is ignored.
REQ-025 Running: a frame counter increments on each frame_tick; when it reaches SCORE_DIV-1 it wraps to 0 and score increments by 1 in BCD, with per-digit carry on 9 -> 0.
REQ-026 Score saturates at 9999 and does not wrap.
REQ-027 Running -> Dead takes priority over a score increment on the same frame_tick.
REQ-028 jump output equals the debounced jump level in every state.
REQ-029 lying output equals debounced down AND (gamestate==Running).
REQ-030 All outputs are registered; the state change reaches gamestate 1 clk after the triggering event.

Reset
REQ-031 While rst==0 at a rising clk: gamestate=00, jump=0, lying=0, score=0000, hiscore=0000, frame_tick=0.
REQ-032 The same reset clears all synchronisers, debounce counters, hit, the frame counter and holdoff.
REQ-033 Reset asserted mid-game (any state) takes effect on the next rising clk and discards hiscore.
REQ-034 After rst returns to 1, no press event fires unless the button is later held stable for DEB_CYCLES.

Verification (DEB_CYCLES=4, SCORE_DIV=2, HOLDOFF=3 in bench)
REQ-035 Reset, then hold btn_jump=1 for 10 clk -> jump=1 after 2+4 sync/debounce clk; gamestate 00->01 on the following clk.
REQ-036 btn_jump toggling every 2 clk for 40 clk -> jump stays 0 and gamestate stays 00.
REQ-037 Running with no overlap for 7 frame ticks -> score=0003 (BCD); preload 0009 then 2 ticks -> 0010; preload 9999 -> stays 9999.
REQ-038 Assert isemptyDino=0 and isemptyObs=0 for 1 clk mid-frame -> gamestate=10 on the clk after the next frame_tick; score frozen; hiscore updated to score.
REQ-039 In Dead, a jump press after 1 tick -> stays 10; a press after 3 ticks -> 00; the next press -> 01 with score=0000 and hiscore retained.
REQ-040 Drive rst=0 for 1 clk while Running with score 0042 -> all outputs at REQ-031 values on that edge.
